// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared encodings for the unified memory arbiter
// Purpose: FSM state codes, DMType memory-access codes and the grant-select result type.
package unified_mem_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  // DMType codes, same values as the pipeline's ctrl_encode_def.v
  localparam logic [2:0] DM_WORD     = 3'b000;
  localparam logic [2:0] DM_HALFWORD = 3'b001;
  localparam logic [2:0] DM_BYTE     = 3'b011;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D    = 2'd2
  } grant_t;

endpackage

// File: rtl/unified_mem_arbiter_arb_grant_sel.sv
// rtl/unified_mem_arbiter_arb_grant_sel.sv - data-priority grant select with starvation bound
// Purpose: picks which requester owns the memory next and tracks the data-grant streak.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   idle          arbiter is free to grant this cycle
//   i_elig        fetch request eligible (pending and not pulsing ready)
//   d_elig        data request eligible (pending and not pulsing ready)
//   if_req        raw fetch request, used to decide whether a D grant extends the streak
//   grant         selection for this cycle (GRANT_NONE when not idle or nothing eligible)
module unified_mem_arbiter_arb_grant_sel
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   idle,
  input  logic   i_elig,
  input  logic   d_elig,
  input  logic   if_req,
  output grant_t grant
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak;

  // Data wins unless the fetch side has already lost STARVE_LIMIT times in a row.
  always_comb begin
    grant = GRANT_NONE;
    if (idle) begin
      if (i_elig && (!d_elig || streak == LIMIT)) begin
        grant = GRANT_I;
      end else if (d_elig) begin
        grant = GRANT_D;
      end
    end
  end

  // A D grant only counts against the fetch side when a fetch was actually waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (grant == GRANT_I) begin
      streak <= '0;
    end else if (grant == GRANT_D) begin
      if (!if_req) begin
        streak <= '0;
      end else if (streak != LIMIT) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one variable-latency memory between fetch and load/store ports
// Purpose: grants one requester at a time, holds the memory request stable until ack,
//   returns read data with a one-cycle ready pulse.
// Ports:
//   fetch side : if_req, if_addr -> if_rdata, if_ready
//   data side  : d_req, d_we, d_type, d_addr, d_wdata -> d_rdata, d_ready
//   memory side: mem_req, mem_we, mem_type, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   stalls     : stall_if, stall_mem (combinational, back to the pipeline)
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_type,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [2:0]    mem_type,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  logic [1:0] state;
  grant_t     grant;
  logic       i_elig;
  logic       d_elig;

  // A requester that is pulsing ready is still holding req for the access just finished.
  assign i_elig = if_req & ~if_ready;
  assign d_elig = d_req & ~d_ready;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  unified_mem_arbiter_arb_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .clk    (clk),
    .reset_n(reset_n),
    .idle   (state == ST_IDLE),
    .i_elig (i_elig),
    .d_elig (d_elig),
    .if_req (if_req),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_type  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // mem_ack is ignored here; only a grant moves the FSM.
          if (grant == GRANT_I) begin
            state    <= ST_GNT_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_type <= DM_WORD;
            mem_addr <= if_addr;
          end else if (grant == GRANT_D) begin
            state     <= ST_GNT_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_type  <= d_type;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        ST_GNT_I: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
            mem_req  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_GNT_D: begin
          if (mem_ack) begin
            // Stores leave the last load result in place.
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_ready <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_type;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and the latched access.
  int          m_owner;
  logic        m_we;
  logic [2:0]  m_type;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  logic        m_if_ready, m_d_ready;
  int          m_streak;

  int   req_cycles, if_pulses, d_pulses;
  logic prev_req;
  logic [31:0] grant_addrs[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_we = 0; m_type = '0; m_addr = '0; m_wdata = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_if_ready = 0; m_d_ready = 0; m_streak = 0;
    prev_req = 0;
  endtask

  task automatic model_step();
    logic i_e, d_e, nif, nd;
    nif = 0; nd = 0;
    if (m_owner == 0) begin
      i_e = if_req && !m_if_ready;
      d_e = d_req && !m_d_ready;
      if (i_e && (!d_e || m_streak == LIMIT)) begin
        m_owner = 1; m_we = 0; m_type = DM_WORD; m_addr = if_addr; m_streak = 0;
      end else if (d_e) begin
        m_owner = 2; m_we = d_we; m_type = d_type; m_addr = d_addr; m_wdata = d_wdata;
        m_streak = if_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
      end
    end else if (mem_ack) begin
      if (m_owner == 1) begin
        m_if_rdata = mem_rdata; nif = 1;
      end else begin
        if (!m_we) m_d_rdata = mem_rdata;
        nd = 1;
      end
      m_owner = 0; m_we = 0;
    end
    m_if_ready = nif;
    m_d_ready  = nd;
  endtask

  task automatic check_outputs();
    check("mem_req", mem_req, m_owner != 0);
    check("mem_we", mem_we, m_we);
    check("mem_type", mem_type, m_type);
    check("mem_addr", mem_addr, m_addr);
    if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    check("if_ready", if_ready, m_if_ready);
    check("d_ready", d_ready, m_d_ready);
    check("if_rdata", if_rdata, m_if_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    check("stall_if", stall_if, if_req && !m_if_ready);
    check("stall_mem", stall_mem, d_req && !m_d_ready);
    if (mem_req) req_cycles++;
    if (if_ready) if_pulses++;
    if (d_ready) d_pulses++;
    if (mem_req && !prev_req) grant_addrs.push_back(mem_addr);
    prev_req = mem_req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Run until a ready pulse, acking on the lat-th cycle of mem_req.
  task automatic serve(input string tag, input int lat, input logic [31:0] rdata);
    int   seen;
    logic done;
    seen = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (if_ready || d_ready) begin
        done = 1;
        mem_ack = 1'b0;
      end else begin
        seen = mem_req ? seen + 1 : 0;
        mem_ack = mem_req && (seen >= lat);
        mem_rdata = rdata;
      end
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    int n_d, n_i;
    logic found_i;
    reset_n = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_type = '0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 0;
    model_reset();
    req_cycles = 0; if_pulses = 0; d_pulses = 0;
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch only, ack on the third request cycle.
    if_req = 1; if_addr = 32'h40; req_cycles = 0; if_pulses = 0;
    serve("fetch", 3, 32'h0000_0013);
    if_req = 0;
    tick();
    check("fetch_req_cycles", req_cycles, 3);
    check("fetch_ready_pulses", if_pulses, 1);
    check("fetch_rdata", if_rdata, 32'h13);

    // Simultaneous fetch and load: data first, fetch granted right after d_ready.
    grant_addrs.delete();
    if_req = 1; if_addr = 32'h44;
    d_req = 1; d_we = 0; d_type = DM_WORD; d_addr = 32'h100;
    serve("dual_d", 1, 32'hDEAD_BEEF);
    check("dual_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 0;
    tick();
    check("dual_i_req_next", mem_req, 1'b1);
    check("dual_i_addr", mem_addr, 32'h44);
    serve("dual_i", 2, 32'h0000_0093);
    if_req = 0;
    check("dual_i_rdata", if_rdata, 32'h93);
    check("dual_order", grant_addrs.size() == 2 && grant_addrs[0] == 32'h100, 1'b1);

    // Store: d_rdata must survive.
    d_req = 1; d_we = 1; d_type = DM_WORD; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    serve("store", 3, 32'hBAD0_BAD0);
    d_req = 0; d_we = 0;
    tick();
    check("store_keeps_rdata", d_rdata, 32'hDEAD_BEEF);

    // Starvation: fetch request absent only in d_ready cycles, so D keeps winning.
    grant_addrs.delete();
    d_req = 1; d_addr = 32'h300; if_req = 1; if_addr = 32'h80;
    found_i = 0;
    for (int k = 0; k < 100 && !found_i; k++) begin
      tick();
      mem_ack = mem_req;
      mem_rdata = k;
      if (if_ready) found_i = 1;
      else if_req = !d_ready;
    end
    d_req = 0; if_req = 0; mem_ack = 0;
    check("starve_done", found_i, 1'b1);
    n_d = 0; n_i = 0;
    foreach (grant_addrs[j]) begin
      if (grant_addrs[j] == 32'h80) n_i++;
      else if (n_i == 0) n_d++;
    end
    check("starve_d_grants", n_d, 4);
    check("starve_i_grants", n_i, 1);
    tick();

    // Reset in the middle of a data grant.
    d_req = 1; d_addr = 32'h500; mem_ack = 0;
    tick(); tick();
    check("pre_reset_req", mem_req, 1'b1);
    d_pulses = 0;
    d_req = 0;
    do_reset();
    check("reset_mem_req", mem_req, 1'b0);
    repeat (4) tick();
    check("reset_no_ready", d_pulses, 0);
    d_req = 1; d_addr = 32'h504;
    serve("post_reset", 1, 32'h5555_AAAA);
    d_req = 0;
    check("post_reset_rdata", d_rdata, 32'h5555_AAAA);

    // Spurious ack while idle, then address change mid-grant.
    if_pulses = 0; d_pulses = 0;
    mem_ack = 1;
    tick(); tick();
    mem_ack = 0;
    check("spurious_no_ready", if_pulses + d_pulses, 0);
    d_req = 1; d_addr = 32'h600;
    tick();
    d_addr = 32'h999;
    tick();
    check("latched_addr", mem_addr, 32'h600);
    serve("addr_change", 2, 32'hCAFE_F00D);
    d_req = 0;

    // Randomized traffic, including protocol-violating request drops and resets.
    for (int k = 0; k < 4000; k++) begin
      tick();
      if ($urandom_range(0, 4) == 0) if_req = ~if_req;
      if ($urandom_range(0, 4) == 0) d_req = ~d_req;
      if_addr   = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_we      = $urandom_range(0, 1);
      d_type    = 3'($urandom_range(0, 7));
      mem_rdata = $urandom;
      mem_ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
